// File: rtl/regfile_pkg.sv
// Shared constants and typedefs for the multi-port integer register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned DEPTH_DEF = 32;
  localparam int unsigned AW_DEF    = $clog2(DEPTH_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: release on accepted write, reserve from issue, flush clears all.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int unsigned DEPTH = DEPTH_DEF,
  parameter  int unsigned NWR   = 2,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NWR-1:0]           wr_en,
  input  logic [NWR-1:0][AW-1:0]   wr_addr,
  input  logic                     rsv_en,
  input  logic [AW-1:0]            rsv_addr,
  input  logic                     flush,
  output logic [DEPTH-1:0]         busy_vec
);

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;

  // Priority low to high: release, reserve (new producer owns it), flush.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int unsigned p = 0; p < NWR; p++) begin
      if (wr_en[p] && (wr_addr[p] != '0)) begin
        w_busy_nxt[wr_addr[p]] = 1'b0;
      end
    end
    if (rsv_en && (rsv_addr != '0)) begin
      w_busy_nxt[rsv_addr] = 1'b1;
    end
    if (flush) begin
      w_busy_nxt = '0;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign busy_vec = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with hardwired-zero x0 and a RAW busy scoreboard.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int unsigned XLEN  = XLEN_DEF,
  parameter  int unsigned DEPTH = DEPTH_DEF,
  parameter  int unsigned NRD   = 2,
  parameter  int unsigned NWR   = 2,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NWR-1:0]             wr_en,
  input  logic [NWR-1:0][AW-1:0]     wr_addr,
  input  logic [NWR-1:0][XLEN-1:0]   wr_data,
  input  logic [NRD-1:0][AW-1:0]     rd_addr,
  output logic [NRD-1:0][XLEN-1:0]   rd_data,
  output logic [NRD-1:0]             rd_busy,
  input  logic                       rsv_en,
  input  logic [AW-1:0]              rsv_addr,
  input  logic                       flush,
  output logic                       busy_any
);

  logic [XLEN-1:0]  r_regs [DEPTH];
  logic [DEPTH-1:0] w_busy_vec;

  // Ports visited in index order so the highest enabled port lands last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned a = 0; a < DEPTH; a++) begin
        r_regs[a] <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < NWR; p++) begin
        if (wr_en[p] && (wr_addr[p] != '0)) begin
          r_regs[wr_addr[p]] <= wr_data[p];
        end
      end
    end
  end

  regfile_scoreboard #(
    .DEPTH (DEPTH),
    .NWR   (NWR)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .flush    (flush),
    .busy_vec (w_busy_vec)
  );

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      rd_data[i] = (rd_addr[i] == '0) ? '0 : r_regs[rd_addr[i]];
      rd_busy[i] = w_busy_vec[rd_addr[i]];
`ifdef REGFILE_BYPASS_EN
      // Forwarded write also shows the release, unless re-reserved this cycle.
      for (int unsigned p = 0; p < NWR; p++) begin
        if (wr_en[p] && (wr_addr[p] != '0) && (wr_addr[p] == rd_addr[i])) begin
          rd_data[i] = wr_data[p];
          rd_busy[i] = rsv_en && (rsv_addr == rd_addr[i]);
        end
      end
`endif
    end
  end

  assign busy_any = |w_busy_vec;

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the pipelined core, successor to the single-cycle core's two-read/one-write file. It provides NRD combinational read ports, NWR synchronous write ports, a hardwired-zero register 0, and a per-register busy scoreboard that the issue stage uses for RAW hazard detection. Writes can optionally be forwarded to same-cycle reads. It sits between decode/issue, which reads and reserves, and writeback, which writes and releases.

## Interface
- XLEN, 32, data width in bits
- DEPTH, 32, number of architectural registers (power of two, ≥ 2)
- NRD, 2, number of read ports
- NWR, 2, number of write ports; higher index has priority
- AW, $clog2(DEPTH), address width (derived, not overridden)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  NWR  per-port write strobe
- wr_addr  in  NWR×AW  write addresses
- wr_data  in  NWR×XLEN  write data
- rd_addr  in  NRD×AW  read addresses
- rd_data  out  NRD×XLEN  read data, combinational
- rd_busy  out  NRD  busy bit of each read address, combinational
- rsv_en  in  1  reserve request (instruction issued with destination)
- rsv_addr  in  AW  register to mark busy
- flush  in  1  clears all busy bits (pipeline flush); register data is untouched
- busy_any  out  1  OR of all busy bits

## Operation
- Reset (rst_n low, asynchronous): all registers 0, all busy bits 0, so rd_data=0, rd_busy=0, busy_any=0. Reset asserted mid-write discards that write.
- Write: at posedge, for each port with wr_en=1 and wr_addr≠0, register ← wr_data. Writes to address 0 are dropped.
- Same-address writes on multiple ports in one cycle: the highest-index enabled port wins.
- Release: any accepted write (wr_en=1, addr≠0) clears that register's busy bit at the same edge.
- Reserve: rsv_en=1 and rsv_addr≠0 sets the busy bit at posedge. rsv_addr=0 is ignored; register 0 is never busy.
- Reserve and release of the same address in the same cycle: reserve wins (the new producer owns it) and busy ends at 1.
- flush=1: all busy bits are 0 after the edge. flush overrides rsv_en in the same cycle.
- Read: rd_data[i] = 0 if rd_addr[i]=0, else the stored register (or the bypassed value, see Configuration). rd_busy[i] = busy[rd_addr[i]].

## Timing
- Write latency: 1 edge; the value is visible on reads after the edge.
- Reserve latency: 1 edge; rd_busy rises the cycle after rsv_en.
- Release latency: 1 edge, or 0 for read visibility with bypass enabled.
- No handshake and no backpressure: every request is accepted in its cycle.

## Configuration
- REGFILE_BYPASS_EN defined: a read whose address matches an enabled, non-zero same-cycle write returns that wr_data (highest-index port on multiple matches), and rd_busy for that address reads 0 unless rsv_en targets it in the same cycle.
- Not defined: reads return the pre-edge stored value and pre-edge busy bit. The issue stage must then stall one extra cycle.

## Structure
- Package regfile_pkg: default XLEN/DEPTH constants and the typedefs reg_addr_t and reg_data_t.
- Sub-module regfile_scoreboard: busy-bit array with reserve/release/flush priority logic. It outputs busy_vec, and busy_any is derived from it.
- The storage array and write-priority mux live in regfile_mp.

## Test plan
- Reset then read all addresses -> every rd_data=0 and rd_busy=0. Assert rst_n low mid-burst -> all outputs 0 immediately.
- Write 0xDEADBEEF to x0 via port 0, then read x0 -> 0. Write 0x12345678 to x5 -> read 0x12345678 the next cycle.
- Ports 0 and 1 both write x7 (0xAAAA0000, 0x5555FFFF) -> x7=0x5555FFFF.
- Same-cycle write x9=0xCAFEF00D and read x9: with REGFILE_BYPASS_EN -> 0xCAFEF00D that cycle; without -> the old value, then 0xCAFEF00D the next cycle.
- Reserve x3 -> rd_busy=1 and busy_any=1 the next cycle. Write x3 while also reserving x3 -> busy stays 1. Write x3 alone -> busy clears.
- Reserve x4 and x6 on consecutive cycles, then flush with rsv_en on x8 -> all busy bits 0, busy_any=0. Register data is unchanged.
